// File: rtl/cu_pkg.sv
// cu_pkg: shared state encoding, opcode classes and ALU timeout for control_unit_p
package cu_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_IMM    = 3'd6,
    S_HALT   = 3'd7
  } state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_BR, C_HALT, C_LDI} cls_t;
  localparam int OPC_NOP = 0;
  // special opcodes are counted down from all-ones: all-ones minus n == ~n
  localparam int OPC_BR_DN   = 0;
  localparam int OPC_HALT_DN = 1;
  localparam int OPC_LDI_DN  = 2;
  localparam int CU_ALU_TMO  = 15;
endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational field extraction and opcode classification of the instruction register
// Ports: ir instruction register in; op/dst/src/ofs/cond fields and cls opcode class out.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int IW  = 16,
  parameter int OPW = 5,
  parameter int RAW = 4,
  parameter int OFW = 10
) (
  input  logic [IW-1:0]  ir,
  output logic [OPW-1:0] op,
  output logic [RAW-1:0] dst,
  output logic [RAW-1:0] src,
  output logic [OFW-1:0] ofs,
  output logic           cond,
  output cls_t           cls
);
  if (IW < OPW + 2 * RAW || IW < OPW + OFW + 1) begin : g_bad_widths
    $error("cu_decoder: IW too narrow for opcode, register and offset fields");
  end
  assign op   = ir[IW-1 -: OPW];
  assign dst  = ir[IW-OPW-1 -: RAW];
  assign src  = ir[IW-OPW-RAW-1 -: RAW];
  assign ofs  = ir[OFW-1:0];
  assign cond = ir[OFW];
  always_comb
    cls = op == OPW'(OPC_NOP)      ? C_NOP  :
          op == ~OPW'(OPC_BR_DN)   ? C_BR   :
          op == ~OPW'(OPC_HALT_DN) ? C_HALT :
          op == ~OPW'(OPC_LDI_DN)  ? C_LDI  : C_ALU;
endmodule

// File: rtl/control_unit_p.sv
// control_unit_p: multi-cycle instruction sequencer driving PC, register bank and ALU strobes
// Ports: clk, rst (synchronous, active-low); instruction/inst_load/inst_ready fetch handshake;
// stall freeze request; alu_done/zero_flag ALU status; en_pc_2/wr_en/branch_en/pc_inc/err
// one-cycle strobes; wr_reg/src_reg/dst_reg/op_code decoded fields; fsm_state state code;
// pc_offset/imm_data jump offset and immediate.
// Macro CONTROL_UNIT_LDI_EN enables the two-word LDI instruction; without it LDI is illegal.
module control_unit_p
  import cu_pkg::*;
#(
  parameter int IW  = 16,
  parameter int OPW = 5,
  parameter int RAW = 4,
  parameter int OFW = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  instruction,
  input  logic           inst_load,
  output logic           inst_ready,
  input  logic           stall,
  input  logic           alu_done,
  input  logic           zero_flag,
  output logic           en_pc_2,
  output logic           wr_en,
  output logic           branch_en,
  output logic           pc_inc,
  output logic [RAW-1:0] wr_reg,
  output logic [RAW-1:0] src_reg,
  output logic [RAW-1:0] dst_reg,
  output logic [OPW-1:0] op_code,
  output logic [4:0]     fsm_state,
  output logic [OFW-1:0] pc_offset,
  output logic [IW-1:0]  imm_data,
  output logic           err
);
  state_t         state;
  logic [IW-1:0]  ir;
  logic [3:0]     cnt;
  logic [OPW-1:0] d_op;
  logic [RAW-1:0] d_dst, d_src;
  logic [OFW-1:0] d_ofs;
  logic           d_cond;
  cls_t           d_cls;

  cu_decoder #(.IW(IW), .OPW(OPW), .RAW(RAW), .OFW(OFW)) u_dec (
    .ir  (ir),
    .op  (d_op),
    .dst (d_dst),
    .src (d_src),
    .ofs (d_ofs),
    .cond(d_cond),
    .cls (d_cls)
  );

  // ready is combinational so a stall blocks the transfer in the same cycle
  assign inst_ready = !stall && (state == S_FETCH || state == S_IMM);
  assign fsm_state  = {2'b00, state};

`ifndef CONTROL_UNIT_LDI_EN
  assign en_pc_2  = 1'b0;
  assign imm_data = '0;
`endif

  // strobes default low every cycle; a stalled edge simply leaves the state pending
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      ir        <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      branch_en <= 1'b0;
      pc_inc    <= 1'b0;
      err       <= 1'b0;
      wr_reg    <= '0;
      src_reg   <= '0;
      dst_reg   <= '0;
      op_code   <= '0;
      pc_offset <= '0;
`ifdef CONTROL_UNIT_LDI_EN
      en_pc_2   <= 1'b0;
      imm_data  <= '0;
`endif
    end else begin
      wr_en     <= 1'b0;
      branch_en <= 1'b0;
      pc_inc    <= 1'b0;
      err       <= 1'b0;
`ifdef CONTROL_UNIT_LDI_EN
      en_pc_2   <= 1'b0;
`endif
      if (!stall)
        case (state)
          S_IDLE: state <= S_FETCH;
          S_FETCH:
            if (inst_load) begin
              ir    <= instruction;
              state <= S_DECODE;
            end
          S_DECODE: begin
            op_code <= d_op;
            src_reg <= d_src;
            dst_reg <= d_dst;
            wr_reg  <= d_dst;
            cnt     <= '0;
            case (d_cls)
              C_NOP: begin
                pc_inc <= 1'b1;
                state  <= S_FETCH;
              end
              C_BR:   state <= S_BRANCH;
              C_HALT: state <= S_HALT;
`ifdef CONTROL_UNIT_LDI_EN
              C_LDI:  state <= S_IMM;
`else
              C_LDI: begin
                err    <= 1'b1;
                pc_inc <= 1'b1;
                state  <= S_FETCH;
              end
`endif
              default: state <= S_EXEC;
            endcase
          end
          S_EXEC:
            if (alu_done) state <= S_WB;
            else if (cnt == 4'(CU_ALU_TMO - 1)) begin
              err    <= 1'b1;
              pc_inc <= 1'b1;
              state  <= S_FETCH;
            end else cnt <= cnt + 4'd1;
          S_WB: begin
            wr_en  <= 1'b1;
            pc_inc <= 1'b1;
            state  <= S_FETCH;
          end
          S_BRANCH: begin
            pc_inc <= 1'b1;
            state  <= S_FETCH;
            if (!d_cond || zero_flag) begin
              branch_en <= 1'b1;
              pc_offset <= d_ofs;
            end
          end
`ifdef CONTROL_UNIT_LDI_EN
          S_IMM:
            if (inst_load) begin
              imm_data <= instruction;
              wr_en    <= 1'b1;
              en_pc_2  <= 1'b1;
              pc_inc   <= 1'b1;
              state    <= S_FETCH;
            end
`endif
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_control_unit_p.sv
// tb_control_unit_p: randomized self-checking bench for control_unit_p against a cycle-count reference model
module tb_control_unit_p;
`ifdef CONTROL_UNIT_LDI_EN
  localparam bit LDI_ON = 1'b1;
`else
  localparam bit LDI_ON = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0, inst_load = 1'b0, stall = 1'b0, alu_done = 1'b0, zero_flag = 1'b0;
  logic [15:0] instruction = '0;
  logic        inst_ready, en_pc_2, wr_en, branch_en, pc_inc, err;
  logic [3:0]  wr_reg, src_reg, dst_reg;
  logic [4:0]  op_code, fsm_state;
  logic [9:0]  pc_offset;
  logic [15:0] imm_data;
  int total = 0, bad = 0;
  int          o_lat;
  logic        o_wr, o_br, o_err, o_pc2, o_stray, o_stst;
  logic [3:0]  o_wreg, o_src, o_dst;
  logic [4:0]  o_op;
  logic [9:0]  o_ofs;
  logic [15:0] o_imm;
  wire any_strobe = wr_en | branch_en | err | en_pc_2 | pc_inc;
  wire [65:0] all_out = {inst_ready, en_pc_2, wr_en, branch_en, pc_inc, err, wr_reg, src_reg,
                         dst_reg, op_code, fsm_state, pc_offset, imm_data};

  always #5 clk = ~clk;

  control_unit_p #(.IW(16), .OPW(5), .RAW(4), .OFW(10)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .inst_load(inst_load), .inst_ready(inst_ready),
    .stall(stall), .alu_done(alu_done), .zero_flag(zero_flag), .en_pc_2(en_pc_2), .wr_en(wr_en),
    .branch_en(branch_en), .pc_inc(pc_inc), .wr_reg(wr_reg), .src_reg(src_reg), .dst_reg(dst_reg),
    .op_code(op_code), .fsm_state(fsm_state), .pc_offset(pc_offset), .imm_data(imm_data), .err(err)
  );

  function automatic bit stalled(int n, int sa, int sl);
    return n >= sa && n < sa + sl;
  endfunction

  // cycle (counted from the accepting edge) in which pc_inc is due; kind: 0 NOP, 1 ALU, 2 BR, 3 LDI
  function automatic int exp_lat(int kind, int k, int sa, int sl);
    int n = 1;
    int e = 0;
    while (stalled(n, sa, sl)) n++;
    n++;
    if (kind == 0 || (kind == 3 && !LDI_ON)) return n;
    if (kind == 1)
      while (1) begin
        if (stalled(n, sa, sl)) n++;
        else if (k >= 0 && n >= 2 + k) begin
          n++;
          break;
        end else if (e == 14) return n + 1;
        else begin
          e++;
          n++;
        end
      end
    while (stalled(n, sa, sl)) n++;
    return n + 1;
  endfunction

  task automatic wait_ready;
    int c = 0;
    #1;
    while (inst_ready !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (inst_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: inst_ready=%b required 1", inst_ready);
    end
  endtask

  // feed one instruction; alu_done rises k cycles after EXEC entry (k<0: never); stall over [sa, sa+sl)
  task automatic run(input logic [15:0] w, input int k, input bit zf, input logic [15:0] imm,
                     input int sa, input int sl);
    logic prev_st = 1'b0;
    bit done = 1'b0;
    o_lat = -1; o_stray = 0; o_stst = 0; o_wr = 0; o_br = 0; o_err = 0; o_pc2 = 0;
    o_wreg = 0; o_src = 0; o_dst = 0; o_op = 0; o_ofs = 0; o_imm = 0;
    stall = 0; alu_done = 0;
    wait_ready();
    instruction = w; inst_load = 1; zero_flag = zf;
    @(posedge clk); #1;
    inst_load = (w[15:11] == 5'd29);
    instruction = imm;
    for (int n = 1; n <= 40 && !done; n++) begin
      alu_done = k >= 0 && n >= 2 + k;
      stall = stalled(n, sa, sl);
      @(negedge clk);
      if (any_strobe) begin
        if (prev_st) o_stst = 1;
        if (o_lat < 0 && pc_inc) begin
          o_lat = n; o_wr = wr_en; o_br = branch_en; o_err = err; o_pc2 = en_pc_2;
          o_wreg = wr_reg; o_src = src_reg; o_dst = dst_reg; o_op = op_code;
          o_ofs = pc_offset; o_imm = imm_data;
          inst_load = 0;
        end else o_stray = 1;
      end
      if (o_lat >= 0 && n > o_lat) done = 1;
      prev_st = stall;
      @(posedge clk); #1;
    end
    stall = 0; alu_done = 0; inst_load = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    total++;
    if (fsm_state !== 5'd0) begin
      bad++;
      $display("FAIL reset_release_idle: fsm_state=%0d required 0", fsm_state);
    end
    @(posedge clk); #1;
    total++;
    if (fsm_state !== 5'd1 || inst_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_to_fetch: fsm_state=%0d inst_ready=%b required 1/1", fsm_state, inst_ready);
    end
  endtask

  task automatic test_alu;
    run(16'h0A58, 3, 0, 16'h0, 0, 0);
    total++;
    if (o_lat !== 7 || o_wr !== 1'b1 || o_err !== 1'b0 || o_stray !== 1'b0) begin
      bad++;
      $display("FAIL alu_wb: lat=%0d wr=%b err=%b stray=%b required 7/1/0/0", o_lat, o_wr, o_err, o_stray);
    end
    total++;
    if (o_wreg !== 4'd4 || o_dst !== 4'd4 || o_src !== 4'd11 || o_op !== 5'd1) begin
      bad++;
      $display("FAIL alu_fields: wr_reg=%0d dst=%0d src=%0d op=%0d required 4/4/11/1", o_wreg, o_dst, o_src, o_op);
    end
    total++;
    if (fsm_state !== 5'd1) begin
      bad++;
      $display("FAIL alu_return: fsm_state=%0d required 1", fsm_state);
    end
  endtask

  task automatic test_branch;
    run(16'hFFF0, 0, 0, 16'h0, 0, 0);
    total++;
    if (o_lat !== 3 || o_br !== 1'b0 || o_stray !== 1'b0) begin
      bad++;
      $display("FAIL branch_not_taken: lat=%0d branch_en=%b stray=%b required 3/0/0", o_lat, o_br, o_stray);
    end
    run(16'hFFF0, 0, 1, 16'h0, 0, 0);
    total++;
    if (o_lat !== 3 || o_br !== 1'b1 || o_ofs !== 10'h3F0) begin
      bad++;
      $display("FAIL branch_taken: lat=%0d branch_en=%b pc_offset=%h required 3/1/3f0", o_lat, o_br, o_ofs);
    end
  endtask

  task automatic test_timeout;
    run(16'h0A58, -1, 0, 16'h0, 0, 0);
    total++;
    if (o_lat !== 17 || o_err !== 1'b1 || o_wr !== 1'b0 || o_stray !== 1'b0) begin
      bad++;
      $display("FAIL alu_timeout: lat=%0d err=%b wr=%b stray=%b required 17/1/0/0", o_lat, o_err, o_wr, o_stray);
    end
  endtask

  task automatic test_stall;
    stall = 1;
    @(negedge clk);
    total++;
    if (inst_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_fetch_ready: inst_ready=%b required 0", inst_ready);
    end
    @(posedge clk); #1;
    stall = 0;
    run(16'h0A58, 3, 0, 16'h0, 6, 4);
    total++;
    if (o_lat !== 11 || o_wr !== 1'b1 || o_wreg !== 4'd4 || o_stst !== 1'b0 || o_stray !== 1'b0) begin
      bad++;
      $display("FAIL stall_wb: lat=%0d wr=%b wr_reg=%0d stalled_strobe=%b stray=%b required 11/1/4/0/0",
               o_lat, o_wr, o_wreg, o_stst, o_stray);
    end
  endtask

  task automatic test_ldi;
    run(16'hE980, 0, 0, 16'hBEEF, 0, 0);
    total++;
    if (o_lat !== (LDI_ON ? 3 : 2) || o_wr !== LDI_ON || o_pc2 !== LDI_ON || o_err !== !LDI_ON) begin
      bad++;
      $display("FAIL ldi_strobes: lat=%0d wr=%b en_pc_2=%b err=%b required %0d/%b/%b/%b",
               o_lat, o_wr, o_pc2, o_err, LDI_ON ? 3 : 2, LDI_ON, LDI_ON, !LDI_ON);
    end
    total++;
    if (o_imm !== (LDI_ON ? 16'hBEEF : 16'h0) || {o_wr, o_wr ? o_wreg : 4'd0} !== {LDI_ON, LDI_ON ? 4'd3 : 4'd0}) begin
      bad++;
      $display("FAIL ldi_data: imm_data=%h wr_reg=%0d required %h/%0d",
               o_imm, o_wreg, LDI_ON ? 16'hBEEF : 16'h0, LDI_ON ? 3 : 0);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 3));
      int k = int'($urandom_range(0, 13)) - 1;
      bit zf = 1'($urandom);
      int sa = int'($urandom_range(1, 8));
      int sl = int'($urandom_range(0, 4));
      logic [15:0] imm = 16'($urandom);
      logic [4:0] op = kind == 0 ? 5'd0 : kind == 1 ? 5'($urandom_range(1, 28)) : kind == 2 ? 5'd31 : 5'd29;
      logic [15:0] w = {op, 11'($urandom)};
      bit e_wr = (kind == 1 && k >= 0) || (kind == 3 && LDI_ON);
      bit e_err = (kind == 1 && k < 0) || (kind == 3 && !LDI_ON);
      bit e_br = kind == 2 && (!w[10] || zf);
      bit e_pc2 = kind == 3 && LDI_ON;
      int e_lat = exp_lat(kind, k, sa, sl);
      run(w, k, zf, imm, sa, sl);
      total++;
      if (o_lat !== e_lat) begin
        bad++;
        $display("FAIL rnd_latency[%0d]: w=%h k=%0d stall=%0d+%0d lat=%0d required %0d", i, w, k, sa, sl, o_lat, e_lat);
      end
      total++;
      if ({o_wr, o_err, o_br, o_pc2} !== {e_wr, e_err, e_br, e_pc2}) begin
        bad++;
        $display("FAIL rnd_strobes[%0d]: w=%h wr/err/br/pc2=%b%b%b%b required %b%b%b%b",
                 i, w, o_wr, o_err, o_br, o_pc2, e_wr, e_err, e_br, e_pc2);
      end
      total++;
      if ({o_op, o_dst, o_src} !== {w[15:11], w[10:7], w[6:3]}) begin
        bad++;
        $display("FAIL rnd_fields[%0d]: op/dst/src=%0d/%0d/%0d required %0d/%0d/%0d",
                 i, o_op, o_dst, o_src, w[15:11], w[10:7], w[6:3]);
      end
      total++;
      if (o_stray !== 1'b0 || o_stst !== 1'b0) begin
        bad++;
        $display("FAIL rnd_pulse[%0d]: w=%h stray=%b stalled_strobe=%b required 0/0", i, w, o_stray, o_stst);
      end
      if (e_wr) begin
        total++;
        if (o_wreg !== w[10:7]) begin
          bad++;
          $display("FAIL rnd_wr_reg[%0d]: wr_reg=%0d required %0d", i, o_wreg, w[10:7]);
        end
      end
      if (e_br) begin
        total++;
        if (o_ofs !== w[9:0]) begin
          bad++;
          $display("FAIL rnd_offset[%0d]: pc_offset=%h required %h", i, o_ofs, w[9:0]);
        end
      end
      if (e_pc2) begin
        total++;
        if (o_imm !== imm) begin
          bad++;
          $display("FAIL rnd_imm[%0d]: imm_data=%h required %h", i, o_imm, imm);
        end
      end
    end
  endtask

  task automatic test_reset_exec;
    wait_ready();
    instruction = 16'h0A58; inst_load = 1; alu_done = 0;
    @(posedge clk); #1;
    inst_load = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (fsm_state !== 5'd3) begin
      bad++;
      $display("FAIL rst_exec_entry: fsm_state=%0d required 3", fsm_state);
    end
    rst = 0;
    @(posedge clk); #1;
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL rst_exec_outputs: got %h required 0", all_out);
    end
    alu_done = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (wr_en !== 1'b0 || fsm_state !== 5'd0) begin
        bad++;
        $display("FAIL rst_exec_hold[%0d]: wr_en=%b fsm_state=%0d required 0/0", i, wr_en, fsm_state);
      end
    end
    rst = 1; alu_done = 0;
    @(posedge clk); #1;
    total++;
    if (fsm_state !== 5'd1) begin
      bad++;
      $display("FAIL rst_exec_restart: fsm_state=%0d required 1", fsm_state);
    end
  endtask

  task automatic test_halt;
    wait_ready();
    instruction = 16'hF000; inst_load = 1;
    @(posedge clk); #1;
    inst_load = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom);
      inst_load = 1'($urandom);
      alu_done = 1'($urandom);
      @(negedge clk);
      total++;
      if (fsm_state !== 5'd7 || any_strobe !== 1'b0 || inst_ready !== 1'b0) begin
        bad++;
        $display("FAIL halt_hold[%0d]: fsm_state=%0d strobes=%b inst_ready=%b required 7/0/0",
                 i, fsm_state, any_strobe, inst_ready);
      end
      @(posedge clk); #1;
    end
    stall = 0; inst_load = 0; alu_done = 0;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_timeout();
    test_stall();
    test_ldi();
    test_random();
    test_reset_exec();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit_p.md
CONTROL_UNIT_P -- requirements
Module: control_unit_p

Interface
REQ-001 SHALL have parameter IW, default 16, instruction word width.
REQ-002 SHALL have parameter OPW, default 5, opcode field width.
REQ-003 SHALL have parameter RAW, default 4, register address width.
REQ-004 SHALL have parameter OFW, default 10, branch offset width.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port instruction  in  IW  instruction or immediate word.
REQ-008 SHALL have port inst_load  in  1  instruction valid.
REQ-009 SHALL have port inst_ready  out  1  unit accepts a word; transfer occurs when inst_load and inst_ready are both high.
REQ-010 SHALL have port stall  in  1  freeze request.
REQ-011 SHALL have port alu_done  in  1  ALU result ready.
REQ-012 SHALL have port zero_flag  in  1  ALU zero, used by conditional branch.
REQ-013 SHALL have port en_pc_2  out  1  PC advances by 2 (two-word instruction).
REQ-014 SHALL have port wr_en  out  1  register bank write strobe.
REQ-015 SHALL have port branch_en  out  1  select offset path for PC.
REQ-016 SHALL have port pc_inc  out  1  PC load strobe.
REQ-017 SHALL have ports wr_reg, src_reg, dst_reg  out  RAW each  register addresses.
REQ-018 SHALL have port op_code  out  OPW  ALU select.
REQ-019 SHALL have port fsm_state  out  5  current state code, zero-extended.
REQ-020 SHALL have ports pc_offset  out  OFW and imm_data  out  IW  jump offset and immediate.
REQ-021 SHALL have port err  out  1  one-cycle pulse on ALU timeout or illegal opcode.

Function
REQ-022 SHALL decode: opcode = IR[IW-1:IW-OPW]; dst = next RAW bits; src = following RAW bits; offset = IR[OFW-1:0]; cond = IR[OFW]; elaboration error unless IW >= OPW+2*RAW and IW >= OPW+OFW+1.
REQ-023 SHALL use opcodes: 0 NOP, all-ones BR, all-ones-1 HALT, all-ones-2 LDI, all others ALU.
REQ-024 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, BRANCH=5, IMM=6, HALT=7; IDLE goes to FETCH one cycle after reset release.
REQ-025 SHALL, in FETCH, drive inst_ready=1, latch instruction into IR on transfer, and go to DECODE.
REQ-026 SHALL, in DECODE, register src_reg/dst_reg/op_code from IR, holding them until the next DECODE; NOP: pc_inc pulse then FETCH; BR to BRANCH; HALT to HALT; LDI to IMM; ALU to EXEC.
REQ-027 SHALL, in EXEC, wait for alu_done and go to WB; after CU_ALU_TMO (15) cycles without alu_done, pulse err and pc_inc, perform no write, and go to FETCH.
REQ-028 SHALL, in WB, pulse wr_en with wr_reg=dst and pulse pc_inc for one cycle, then go to FETCH.
REQ-029 SHALL, in BRANCH, pulse pc_inc; also pulse branch_en with pc_offset=offset if cond=0 or zero_flag=1; then go to FETCH.
REQ-030 SHALL hold HALT, with all strobes 0 and inst_ready 0, until reset.
REQ-031 SHALL, while stall=1 in any state except HALT: hold state, hold IR and counter, force inst_ready and all strobes to 0, and issue any pending strobe on the first unstalled cycle.
REQ-032 SHALL never assert more than one of wr_en/branch_en without pc_inc in the same cycle; all strobes are exactly one cycle wide.

Reset
REQ-033 SHALL, on a clock edge with rst=0, enter IDLE regardless of state: all outputs 0, IR and counter cleared, any in-flight instruction discarded with no wr_en.

Configuration
REQ-034 SHALL, with CONTROL_UNIT_LDI_EN defined, in IMM accept a second word via handshake, drive imm_data with it, and pulse wr_en (wr_reg=dst), en_pc_2 and pc_inc together, then go to FETCH.
REQ-035 SHALL, without CONTROL_UNIT_LDI_EN, treat LDI as illegal: pulse err and pc_inc, go to FETCH, never enter IMM; en_pc_2 and imm_data are tied 0.

Structure
REQ-036 SHALL place the state encoding, opcode constants and CU_ALU_TMO in shared package cu_pkg.
REQ-037 SHALL implement field extraction and opcode classification in combinational sub-module cu_decoder.

Verification
REQ-038 SHALL cover: ALU op 16'h0A5_8 (op 1, dst 4, src 11), alu_done 3 cycles after EXEC -> one wr_en with wr_reg=4, pc_inc in the same cycle, return to FETCH.
REQ-039 SHALL cover: BR with cond=1, offset 10'h3F0 -> branch_en=0 when zero_flag=0, and branch_en=1 with pc_offset=3F0 when zero_flag=1; pc_inc=1 in both cases.
REQ-040 SHALL cover: ALU op with alu_done never asserted -> err and pc_inc pulse 15 cycles after EXEC entry, no wr_en.
REQ-041 SHALL cover: stall held 4 cycles during WB -> no strobes while stalled, then wr_en+pc_inc on the cycle after release.
REQ-042 SHALL cover: LDI followed by word 16'hBEEF -> imm_data=BEEF with wr_en, en_pc_2 and pc_inc in the same cycle (macro on); err pulse only (macro off).
REQ-043 SHALL cover: rst=0 during EXEC -> fsm_state=0 and all outputs 0 on the next edge; HALT opcode -> fsm_state=7 held for 20 cycles.
